// File: rtl/fc_argmax_reader.sv
// ----------------------------------------------------------------------------
// fc_argmax_reader
//   Consumer end of the fully-connected layer's output vector. Captures one
//   packed score vector per frame and scans it one element per cycle. It then
//   returns the winning class index and score through a valid/ready handshake.
//   Ties keep the lowest index.
//
// Ports
//   clk           in   clock, all logic on rising edge
//   rst_n         in   synchronous active-low reset
//   scores_in     in   packed scores, element k = [k*SCORE_WIDTH +: SCORE_WIDTH]
//   scores_valid  in   scores_in valid
//   scores_ready  out  block can accept a vector (state == IDLE)
//   class_idx     out  winning class index (registered)
//   class_score   out  winning score (registered)
//   class_valid   out  result valid (registered)
//   class_ready   in   downstream accepts result
//   busy          out  state != IDLE
//
// Configuration
//   FC_ARGMAX_THRESHOLD_EN : when defined, a best score below THRESHOLD
//   reports class_idx = all ones. class_score still carries the true best
//   score. When undefined, THRESHOLD is unused.
// ----------------------------------------------------------------------------
module fc_argmax_reader #(
  parameter int unsigned NUM_CLASSES = 8,
  parameter int unsigned SCORE_WIDTH = 16,
  parameter int unsigned IDX_WIDTH   = 4,
  parameter logic [SCORE_WIDTH-1:0] THRESHOLD = 16'h0100
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CLASSES*SCORE_WIDTH-1:0] scores_in,
  input  logic                               scores_valid,
  output logic                               scores_ready,
  output logic [IDX_WIDTH-1:0]               class_idx,
  output logic [SCORE_WIDTH-1:0]             class_score,
  output logic                               class_valid,
  input  logic                               class_ready,
  output logic                               busy
);

  localparam int unsigned SEL_W = $clog2(NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [SCORE_WIDTH-1:0] elems [NUM_CLASSES];
  logic [IDX_WIDTH-1:0]   cnt;
  logic [SCORE_WIDTH-1:0] best_score;
  logic [IDX_WIDTH-1:0]   best_idx;

  logic [SCORE_WIDTH-1:0] cur_score;
  logic                   take;
  logic [SCORE_WIDTH-1:0] nxt_score;
  logic [IDX_WIDTH-1:0]   nxt_idx;
  logic                   last;
  logic [IDX_WIDTH-1:0]   result_idx;

  assign scores_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  // cnt never exceeds NUM_CLASSES-1, so its low SEL_W bits address the buffer.
  always_comb begin
    cur_score = elems[cnt[SEL_W-1:0]];
    take      = (cur_score > best_score);
    nxt_score = take ? cur_score : best_score;
    nxt_idx   = take ? cnt : best_idx;
    last      = (cnt == IDX_WIDTH'(NUM_CLASSES - 1));
  end

`ifdef FC_ARGMAX_THRESHOLD_EN
  always_comb begin
    result_idx = (nxt_score < THRESHOLD) ? '1 : nxt_idx;
  end
`else
  logic unused_threshold;
  assign unused_threshold = ^THRESHOLD;
  always_comb begin
    result_idx = nxt_idx;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      class_valid <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      cnt         <= '0;
      best_score  <= '0;
      best_idx    <= '0;
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        elems[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (scores_valid) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
              elems[k] <= scores_in[k*SCORE_WIDTH +: SCORE_WIDTH];
            end
            best_score <= scores_in[SCORE_WIDTH-1:0];
            best_idx   <= '0;
            cnt        <= IDX_WIDTH'(1);
            state      <= SCAN;
          end
        end
        SCAN: begin
          best_score <= nxt_score;
          best_idx   <= nxt_idx;
          if (last) begin
            class_idx   <= result_idx;
            class_score <= nxt_score;
            class_valid <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + IDX_WIDTH'(1);
          end
        end
        DONE: begin
          if (class_ready) begin
            class_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          class_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax_reader.sv
module tb_fc_argmax_reader;

  localparam int NC = 8;
  localparam int SW = 16;
  localparam int IW = 4;
  localparam logic [SW-1:0] THR = 16'h0100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC*SW-1:0]  scores_in;
  logic              scores_valid;
  logic              scores_ready;
  logic [IW-1:0]     class_idx;
  logic [SW-1:0]     class_score;
  logic              class_valid;
  logic              class_ready;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fc_argmax_reader #(
    .NUM_CLASSES(NC),
    .SCORE_WIDTH(SW),
    .IDX_WIDTH(IW),
    .THRESHOLD(THR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scores_in(scores_in),
    .scores_valid(scores_valid),
    .scores_ready(scores_ready),
    .class_idx(class_idx),
    .class_score(class_score),
    .class_valid(class_valid),
    .class_ready(class_ready),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first maximum wins; optional rejection below threshold.
  task automatic ref_argmax(input logic [NC*SW-1:0] v, output logic [IW-1:0] idx,
                            output logic [SW-1:0] sc);
    logic [SW-1:0] e;
    sc  = v[SW-1:0];
    idx = '0;
    for (int k = 1; k < NC; k++) begin
      e = v[k*SW +: SW];
      if (e > sc) begin
        sc  = e;
        idx = IW'(k);
      end
    end
`ifdef FC_ARGMAX_THRESHOLD_EN
    if (sc < THR) idx = '1;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*SW-1:0] rand_vec();
    logic [NC*SW-1:0] v;
    for (int k = 0; k < NC; k++) begin
      if ($urandom_range(0, 1) == 1) v[k*SW +: SW] = SW'($urandom_range(0, 7));
      else                           v[k*SW +: SW] = SW'($urandom);
    end
    return v;
  endfunction

  // Sends one frame, checks latency and result, holds class_ready low for
  // 'hold' cycles, then completes the handshake. With keep_valid, scores_valid
  // stays high and scores_in switches to next_v right after capture.
  task automatic run_frame(input logic [NC*SW-1:0] v, input int hold, input bit keep_valid,
                           input logic [NC*SW-1:0] next_v, input string tag);
    logic [IW-1:0] e_idx;
    logic [SW-1:0] e_sc;
    int  w;
    int  lat;
    bit  ready_bad;
    bit  out_moved;
    ref_argmax(v, e_idx, e_sc);
    w = 0;
    while (!scores_ready && w < 50) begin
      tick();
      w++;
    end
    check({tag, "_rdy"}, 32'(scores_ready), 32'd1);
    scores_in    = v;
    scores_valid = 1'b1;
    tick();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (keep_valid) begin
      scores_in = next_v;
    end else begin
      scores_valid = 1'b0;
      scores_in    = rand_vec();
    end
    lat       = 0;
    ready_bad = 1'b0;
    while (!class_valid && lat < 40) begin
      if (scores_ready) ready_bad = 1'b1;
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(NC - 1));
    check({tag, "_rdy_scan"}, 32'(ready_bad), 32'd0);
    check({tag, "_idx"}, 32'(class_idx), 32'(e_idx));
    check({tag, "_score"}, 32'(class_score), 32'(e_sc));
    if (hold > 0) begin
      out_moved = 1'b0;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (!class_valid || class_idx !== e_idx || class_score !== e_sc || scores_ready)
          out_moved = 1'b1;
      end
      check({tag, "_hold"}, 32'(out_moved), 32'd0);
    end
    class_ready = 1'b1;
    tick();
    class_ready = 1'b0;
    check({tag, "_vld_clr"}, 32'(class_valid), 32'd0);
  endtask

  initial begin : main
    logic [NC*SW-1:0] v;
    logic [NC*SW-1:0] v2;
    int  seen;
    rst_n        = 1'b0;
    scores_in    = '0;
    scores_valid = 1'b0;
    class_ready  = 1'b0;

    // Reset held two cycles
    tick();
    tick();
    check("rst_vld", 32'(class_valid), 32'd0);
    check("rst_idx", 32'(class_idx), 32'd0);
    check("rst_score", 32'(class_score), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_rdy", 32'(scores_ready), 32'd1);

    // Basic frame with backpressure
    v = {16'd8, 16'd7, 16'd6, 16'd5, 16'd40, 16'd300, 16'd20, 16'd10};
    run_frame(v, 5, 1'b0, '0, "basic");

    // Tie between e1 and e5
    v = {16'h0010, 16'h0020, 16'h0500, 16'h0030, 16'h0040, 16'h0050, 16'h0500, 16'h0060};
    run_frame(v, 0, 1'b0, '0, "tie");

    // scores_valid held high across two vectors
    v  = {16'd1, 16'd2, 16'd3, 16'd900, 16'd4, 16'd5, 16'd6, 16'd7};
    v2 = {16'd1000, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd1000};
    run_frame(v, 2, 1'b1, v2, "b2b_a");
    check("b2b_rdy_next", 32'(scores_ready), 32'd1);
    run_frame(v2, 1, 1'b0, '0, "b2b_b");

    // Reset during the third SCAN cycle discards the frame
    v = {16'd5, 16'd900, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
    scores_in    = v;
    scores_valid = 1'b1;
    tick();
    scores_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_vld", 32'(class_valid), 32'd0);
    check("midrst_idx", 32'(class_idx), 32'd0);
    check("midrst_score", 32'(class_score), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (class_valid) seen++;
      tick();
    end
    check("midrst_no_pulse", 32'(seen), 32'd0);
    v = {16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_frame(v, 0, 1'b0, '0, "after_rst");

    // Threshold boundary at e3
    v = {16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h00FF, 16'h0001, 16'h0002, 16'h0003};
    run_frame(v, 0, 1'b0, '0, "thr_below");
    v = {16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0100, 16'h0001, 16'h0002, 16'h0003};
    run_frame(v, 0, 1'b0, '0, "thr_equal");

    // Randomized frames
    for (int n = 0; n < 25; n++) begin
      run_frame(rand_vec(), int'($urandom_range(0, 3)), 1'b0, '0, "rand");
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
